// File: rtl/redge_gen_pkg.sv
// Shared types and default constants for the redge_gen debounced press-strobe generator.
package redge_gen_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_e;

    localparam int unsigned DEF_CNT_W           = 4;
    localparam int unsigned DEF_EVT_W           = 8;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/redge_gen.sv
// Debounces a raw button and issues one registered increment strobe per accepted press.
// Define REDGE_GEN_SYNC_EN to put a 2-flop synchronizer in front of the debouncer.
module redge_gen
    import redge_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned EVT_W           = DEF_EVT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             btn,
    input  logic [CNT_W-1:0] cnt_fb,
    output logic             redge,
    output logic [CNT_W-1:0] inputs,
    output logic             btn_db,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    logic w_s;

`ifdef REDGE_GEN_SYNC_EN
    sync_2ff u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (btn),
        .q       (w_s)
    );
`else
    logic r_samp;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_samp <= 1'b0;
        end else begin
            r_samp <= btn;
        end
    end

    assign w_s = r_samp;
`endif

    state_e          r_state;
    state_e          w_state_d;
    logic [DW-1:0]   r_dcnt;
    logic [DW-1:0]   w_dcnt_d;
    logic            r_redge;
    logic            w_redge_d;
    logic [CNT_W-1:0] r_inputs;
    logic [EVT_W-1:0] r_evt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE_LO;
            r_dcnt  <= '0;
            r_redge <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_dcnt  <= w_dcnt_d;
            r_redge <= w_redge_d;
        end
    end

    // Only the press path raises the strobe; release qualification is silent.
    always_comb begin
        w_state_d = r_state;
        w_dcnt_d  = r_dcnt;
        w_redge_d = 1'b0;
        unique case (r_state)
            IDLE_LO: begin
                if (w_s) begin
                    w_state_d = CHK_HI;
                    w_dcnt_d  = DW'(1);
                end
            end
            CHK_HI: begin
                if (!w_s) begin
                    w_state_d = IDLE_LO;
                    w_dcnt_d  = '0;
                end else if (r_dcnt == DLAST) begin
                    w_state_d = IDLE_HI;
                    w_dcnt_d  = '0;
                    w_redge_d = 1'b1;
                end else begin
                    w_dcnt_d  = r_dcnt + DW'(1);
                end
            end
            IDLE_HI: begin
                if (!w_s) begin
                    w_state_d = CHK_LO;
                    w_dcnt_d  = DW'(1);
                end
            end
            CHK_LO: begin
                if (w_s) begin
                    w_state_d = IDLE_HI;
                    w_dcnt_d  = '0;
                end else if (r_dcnt == DLAST) begin
                    w_state_d = IDLE_LO;
                    w_dcnt_d  = '0;
                end else begin
                    w_dcnt_d  = r_dcnt + DW'(1);
                end
            end
            default: begin
                w_state_d = IDLE_LO;
                w_dcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        btn_db = 1'b0;
        unique case (r_state)
            IDLE_HI, CHK_LO: btn_db = 1'b1;
            default:         btn_db = 1'b0;
        endcase
    end

    // Feedback is delayed one cycle so the value is settled when the strobe fires.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inputs <= '0;
            r_evt    <= '0;
        end else begin
            r_inputs <= cnt_fb;
            if (r_redge && (r_evt != {EVT_W{1'b1}})) begin
                r_evt <= r_evt + EVT_W'(1);
            end
        end
    end

    assign redge   = r_redge;
    assign inputs  = r_inputs;
    assign evt_cnt = r_evt;

endmodule

// File: tb/tb_redge_gen.sv
// Directed self-checking bench for redge_gen; a second instance uses EVT_W=2 for saturation.
module tb_redge_gen;

    localparam int DB = 4;
`ifdef REDGE_GEN_SYNC_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 1 + DB;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn     = 1'b0;
    logic [3:0] cnt_fb  = 4'h0;

    logic       redge, btn_db;
    logic [3:0] inputs;
    logic [7:0] evt_cnt;
    logic       redge2, btn_db2;
    logic [3:0] inputs2;
    logic [1:0] evt2;
    logic [3:0] ds_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    redge_gen #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .EVT_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (btn),
        .cnt_fb  (cnt_fb),
        .redge   (redge),
        .inputs  (inputs),
        .btn_db  (btn_db),
        .evt_cnt (evt_cnt)
    );

    redge_gen #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .EVT_W(2)) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .btn     (btn),
        .cnt_fb  (cnt_fb),
        .redge   (redge2),
        .inputs  (inputs2),
        .btn_db  (btn_db2),
        .evt_cnt (evt2)
    );

    // Downstream counter: loads inputs+1 on each strobe.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ds_cnt <= 4'h0;
        else if (redge) ds_cnt <= inputs + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        btn     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Run n cycles, recording first strobe edge index and values around it.
    task automatic hold(input int n, output int lat, output int np, output logic [3:0] inp_at,
                        output logic [7:0] evt_at, output logic [7:0] evt_nx,
                        output logic db_seen);
        lat = -1; np = 0; inp_at = '0; evt_at = '0; evt_nx = '0; db_seen = 1'b0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (btn_db) db_seen = 1'b1;
            if (redge === 1'b1) begin
                np++;
                if (lat < 0) begin
                    lat    = i;
                    inp_at = inputs;
                    evt_at = evt_cnt;
                end
            end
            if (lat > 0 && i == lat + 1) evt_nx = evt_cnt;
        end
    endtask

    initial begin
        int         lat, np, np_tot;
        logic [3:0] ia;
        logic [7:0] ea, en;
        logic       ds, ds_any;
        logic [1:0] exp2 [5];
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;

        // Reset state while reset_n is low, with live feedback that must not leak through
        reset_n = 1'b0;
        cnt_fb  = 4'h5;
        tick();
        tick();
        check("rst_redge", 32'(redge), 32'd0);
        check("rst_btn_db", 32'(btn_db), 32'd0);
        check("rst_inputs", 32'(inputs), 32'd0);
        check("rst_evt", 32'(evt_cnt), 32'd0);
        reset_n = 1'b1;
        tick();
        check("inputs_follow", 32'(inputs), 32'h5);
        cnt_fb = 4'h9;
        tick();
        check("inputs_delay", 32'(inputs), 32'h9);

        // Clean press held 20 cycles
        btn = 1'b1;
        hold(20, lat, np, ia, ea, en, ds);
        check("press_latency", 32'(lat), 32'(LAT));
        check("press_pulses", 32'(np), 32'd1);
        check("press_inputs", 32'(ia), 32'h9);
        check("press_evt_at", 32'(ea), 32'd0);
        check("press_evt_next", 32'(en), 32'd1);
        check("press_btn_db", 32'(btn_db), 32'd1);
        btn = 1'b0;
        hold(12, lat, np, ia, ea, en, ds);
        check("release_pulses", 32'(np), 32'd0);
        check("release_btn_db", 32'(btn_db), 32'd0);
        check("release_evt", 32'(evt_cnt), 32'd1);

        // Short glitches: 3 high, 3 low, five times
        do_reset();
        np_tot = 0;
        ds_any = 1'b0;
        for (int g = 0; g < 5; g++) begin
            btn = 1'b1;
            hold(3, lat, np, ia, ea, en, ds);
            np_tot += np;
            ds_any |= ds;
            btn = 1'b0;
            hold(3, lat, np, ia, ea, en, ds);
            np_tot += np;
            ds_any |= ds;
        end
        hold(8, lat, np, ia, ea, en, ds);
        np_tot += np;
        ds_any |= ds;
        check("glitch_pulses", 32'(np_tot), 32'd0);
        check("glitch_btn_db", 32'(ds_any), 32'd0);
        check("glitch_evt", 32'(evt_cnt), 32'd0);

        // Feedback 7 captured in the strobe cycle; downstream counter reaches 8
        do_reset();
        cnt_fb = 4'h7;
        tick();
        btn = 1'b1;
        hold(LAT + 4, lat, np, ia, ea, en, ds);
        check("fb_inputs_at_redge", 32'(ia), 32'h7);
        check("fb_downstream", 32'(ds_cnt), 32'h8);
        btn = 1'b0;
        hold(12, lat, np, ia, ea, en, ds);

        // Reset two cycles into CHK_HI, released with btn still high
        do_reset();
        btn = 1'b1;
        repeat (LAT - 2) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_redge", 32'(redge), 32'd0);
        tick();
        tick();
        check("midrst_evt", 32'(evt_cnt), 32'd0);
        check("midrst_btn_db", 32'(btn_db), 32'd0);
        reset_n = 1'b1;
        hold(LAT + 4, lat, np, ia, ea, en, ds);
        check("midrst_latency", 32'(lat), 32'(LAT));
        check("midrst_pulses", 32'(np), 32'd1);
        check("midrst_evt_after", 32'(evt_cnt), 32'd1);
        btn = 1'b0;
        hold(12, lat, np, ia, ea, en, ds);

        // Reset asserted while the strobe is high clears it at once and drops the event
        do_reset();
        btn = 1'b1;
        repeat (LAT) tick();
        check("pulse_before_rst", 32'(redge), 32'd1);
        reset_n = 1'b0;
        #1;
        check("pulse_cut_by_rst", 32'(redge), 32'd0);
        btn = 1'b0;
        tick();
        check("pulse_rst_evt", 32'(evt_cnt), 32'd0);
        reset_n = 1'b1;
        hold(12, lat, np, ia, ea, en, ds);
        check("pulse_rst_no_pulse", 32'(np), 32'd0);
        check("pulse_rst_evt_after", 32'(evt_cnt), 32'd0);

        // Five clean presses: 8-bit counter counts on, 2-bit counter saturates at 3
        do_reset();
        for (int p = 0; p < 5; p++) begin
            btn = 1'b1;
            hold(LAT + 4, lat, np, ia, ea, en, ds);
            btn = 1'b0;
            hold(12, lat, np, ia, ea, en, ds);
            check("sat_evt8", 32'(evt_cnt), 32'(p + 1));
            check("sat_evt2", 32'(evt2), 32'(exp2[p]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/redge_gen.md
REDGE_GEN -- requirements
Module: redge_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples needed to accept a level change; SHALL be >= 2.
REQ-002 Parameter CNT_W, default 4: width of counter feedback and value outputs.
REQ-003 Parameter EVT_W, default 8: width of the press-event counter.
REQ-004 Port: clock  input  1  single rising-edge clock for all state.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion is sampled on clock.
REQ-006 Port: btn  input  1  raw, bouncy, asynchronous press input; 1 = pressed.
REQ-007 Port: cnt_fb  input  CNT_W  current value fed back from the downstream synchronous counter output.
REQ-008 Port: redge  output  1  one-cycle increment strobe to the downstream counter.
REQ-009 Port: inputs  output  CNT_W  value the downstream counter loads plus one on redge.
REQ-010 Port: btn_db  output  1  debounced button level.
REQ-011 Port: evt_cnt  output  EVT_W  saturating count of redge pulses issued.

Function
REQ-012 The sampled input s SHALL come from the input stage defined in REQ-027/REQ-028.
REQ-013 FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO; btn_db SHALL be 1 in IDLE_HI and CHK_LO, else 0.
REQ-014 IDLE_LO: s=1 -> CHK_HI with dcnt<=1; s=0 -> stay.
REQ-015 CHK_HI: s=0 -> IDLE_LO with dcnt<=0; s=1 with dcnt==DEBOUNCE_CYCLES-1 -> IDLE_HI with dcnt<=0 and redge<=1; otherwise dcnt<=dcnt+1.
REQ-016 IDLE_HI: s=0 -> CHK_LO with dcnt<=1; s=1 -> stay.
REQ-017 CHK_LO: s=1 -> IDLE_HI with dcnt<=0; s=0 with dcnt==DEBOUNCE_CYCLES-1 -> IDLE_LO with dcnt<=0; otherwise dcnt<=dcnt+1; no redge on release.
REQ-018 redge SHALL be registered, high exactly one cycle per accepted press, and never reassert without an intervening accepted release.
REQ-019 inputs SHALL register cnt_fb every cycle (one-cycle delay), so inputs is stable and valid in every cycle redge is high.
REQ-020 evt_cnt SHALL increment by 1 in the cycle after each redge pulse and saturate at 2^EVT_W-1 without wrap.
REQ-021 dcnt width SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits; dcnt SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES samples SHALL return the FSM to its prior idle state with no output change.

Reset
REQ-023 While reset_n=0: state=IDLE_LO, dcnt=0, redge=0, btn_db=0, inputs=0, evt_cnt=0, synchronizer flops=0.
REQ-024 Reset asserted mid-debounce or during a redge pulse SHALL abort it; no pulse SHALL be emitted for that press.
REQ-025 If btn is held high through reset release, it SHALL be debounced as a new press and produce one redge.
REQ-026 Reset deassertion SHALL be synchronous to clock and free of glitches on redge.

Configuration
REQ-027 With REDGE_GEN_SYNC_EN defined, s SHALL be the output of a 2-flop synchronizer on btn; press-to-redge latency = 2+DEBOUNCE_CYCLES clock edges.
REQ-028 Without REDGE_GEN_SYNC_EN, s SHALL be a single sampling flop on btn; press-to-redge latency = 1+DEBOUNCE_CYCLES clock edges.

Structure
REQ-029 Package redge_gen_pkg SHALL hold the FSM state enum typedef and the default constants for CNT_W, EVT_W and DEBOUNCE_CYCLES.
REQ-030 The synchronizer SHALL be the sub-module sync_2ff (clock, reset_n, d, q), instantiated only under REDGE_GEN_SYNC_EN.

Verification (DEBOUNCE_CYCLES=4, REDGE_GEN_SYNC_EN defined unless stated otherwise)
REQ-031 btn 0->1 held 20 cycles -> redge high exactly one cycle, 6 edges after the rise; btn_db=1; evt_cnt=1.
REQ-032 btn high pulses of 3 cycles repeated 5 times -> redge never asserts, btn_db stays 0, evt_cnt=0.
REQ-033 cnt_fb=4'b0111 held, clean press -> inputs=4'b0111 in the redge cycle; downstream counter reads 4'b1000.
REQ-034 reset_n pulled low 2 cycles into CHK_HI, then released with btn high -> no pulse during reset, then one redge 6 edges after release, evt_cnt=1.
REQ-035 EVT_W=2 with 5 clean presses -> evt_cnt reads 1,2,3,3,3.
REQ-036 Macro undefined, clean press -> redge 5 edges after the rise.
